// File: rtl/hci_stream_store_packer_pkg.sv
// Shared types for the HCI stream store packer: FSM state, job control and status flags.
package hci_stream_store_packer_pkg;

    // Job length is carried zero-extended to this width inside the control struct.
    localparam int HCI_PACKER_LEN_MAX_W = 32;

    typedef enum logic [1:0] {
        PACKER_IDLE  = 2'd0,
        PACKER_PACK  = 2'd1,
        PACKER_DRAIN = 2'd2
    } hci_packer_state_t;

    typedef struct packed {
        logic                            start;
        logic [HCI_PACKER_LEN_MAX_W-1:0] len;
    } hci_packer_ctrl_t;

    typedef struct packed {
        logic busy;
        logic done;
    } hci_packer_flags_t;

    // Number of narrow lanes per wide word.
    function automatic int packer_ratio(input int in_dw, input int out_dw);
        return out_dw / in_dw;
    endfunction

endpackage

// File: rtl/hci_stream_store_packer.sv
// Packs narrow HWPE-Stream beats into wide words (lane 0 first) for the HCI sink
// streamer. The last word of a job may be partial; unused lanes are strb=0/data=0.
module hci_stream_store_packer
    import hci_stream_store_packer_pkg::*;
#(
    parameter int IN_DW  = 32,
    parameter int OUT_DW = 256,
    parameter int LEN_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  in_valid_i,
    input  logic [IN_DW-1:0]      in_data_i,
    input  logic [IN_DW/8-1:0]    in_strb_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [OUT_DW-1:0]     out_data_o,
    output logic [OUT_DW/8-1:0]   out_strb_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int R  = packer_ratio(IN_DW, OUT_DW);
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int SW = IN_DW / 8;

    hci_packer_state_t        r_state;
    hci_packer_flags_t        r_flags;
    logic [LEN_W-1:0]         r_len_q;
    logic [LEN_W-1:0]         r_beat_q;
    logic [LW-1:0]            r_lane_q;
    logic                     r_full_q;
    logic [R-1:0][IN_DW-1:0]  r_buf_data;
    logic [R-1:0][SW-1:0]     r_buf_strb;
    logic                     r_out_valid;
    logic [OUT_DW-1:0]        r_out_data;
    logic [OUT_DW/8-1:0]      r_out_strb;

    hci_packer_ctrl_t         w_ctrl;
    logic                     w_xfer;
    logic                     w_in_ready;
    logic                     w_accept;
    logic [LW-1:0]            w_wlane;
    logic                     w_last;
    logic                     w_lane_top;

    assign w_ctrl     = '{start: start_i, len: HCI_PACKER_LEN_MAX_W'(len_i)};
    assign w_xfer     = enable_i & r_full_q & (~r_out_valid | out_ready_i);
    assign w_in_ready = enable_i & (r_state == PACKER_PACK) & (~r_full_q | w_xfer);
    assign w_accept   = in_valid_i & w_in_ready;
    // A beat arriving alongside a transfer goes into lane 0 of the freshly cleared buffer.
    assign w_wlane    = w_xfer ? '0 : r_lane_q;
    assign w_last     = (r_beat_q == r_len_q - LEN_W'(1));
    assign w_lane_top = (w_wlane == LW'(R - 1));

    // Job sequencing: IDLE -> PACK -> DRAIN -> IDLE, with registered busy/done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= PACKER_IDLE;
            r_flags  <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
        end else if (clear_i) begin
            r_state  <= PACKER_IDLE;
            r_flags  <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
        end else begin
            r_flags.done <= 1'b0;
            if (w_accept) r_beat_q <= r_beat_q + LEN_W'(1);
            case (r_state)
                PACKER_IDLE: begin
                    if (w_ctrl.start) begin
                        if (w_ctrl.len == '0) begin
                            r_flags.done <= 1'b1;
                        end else begin
                            r_len_q      <= len_i;
                            r_beat_q     <= '0;
                            r_state      <= PACKER_PACK;
                            r_flags.busy <= 1'b1;
                        end
                    end
                end
                PACKER_PACK: begin
                    if (w_accept && w_last) r_state <= PACKER_DRAIN;
                end
                PACKER_DRAIN: begin
                    // Last word has left the output register and nothing is pending.
                    if (r_out_valid && out_ready_i && !r_full_q) begin
                        r_flags.done <= 1'b1;
                        r_flags.busy <= 1'b0;
                        r_state      <= PACKER_IDLE;
                    end
                end
                default: r_state <= PACKER_IDLE;
            endcase
        end
    end

    // Pack buffer, lane pointer and full flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_data <= '0;
            r_buf_strb <= '0;
            r_lane_q   <= '0;
            r_full_q   <= 1'b0;
        end else if (clear_i) begin
            r_buf_data <= '0;
            r_buf_strb <= '0;
            r_lane_q   <= '0;
            r_full_q   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_buf_data <= '0;
                r_buf_strb <= '0;
                r_lane_q   <= '0;
                r_full_q   <= 1'b0;
            end
            if (w_accept) begin
                r_buf_data[w_wlane] <= in_data_i;
                r_buf_strb[w_wlane] <= in_strb_i;
                r_lane_q            <= w_lane_top ? '0 : w_wlane + LW'(1);
                if (w_lane_top || w_last) r_full_q <= 1'b1;
            end
        end
    end

    // Single-entry output register; handshake is independent of enable_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
        end else if (clear_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf_data;
            r_out_strb  <= r_buf_strb;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_strb_o  = r_out_strb;
    assign busy_o      = r_flags.busy;
    assign done_o      = r_flags.done;

endmodule
